fetch_dispatch_ctrl: RTL and testbench

- In-order instruction buffer and dual-lane dispatch scheduler between the icache fetch port and the two decoders.
- Accepts 4-wide fetch bundles with a per-slot valid mask and compacts them into a circular buffer.
- Issues the oldest two instructions per cycle to the decode1/decode2 lane registers.
- Discards stale in-flight fetch data after a redirect using a 1-bit fetch epoch.

---
 rtl/fetch_dispatch_ctrl_if.sv | 38 +++
 rtl/fetch_dispatch_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_dispatch_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_dispatch_ctrl_if.sv
// Fetch/decode bus for fetch_dispatch_ctrl.
//   Fetch side   : in_valid/in_mask/in_pc/in_inst/in_epoch -> ; <- in_ready, cur_epoch
//   Decode side  : flush/stall1/stall2 -> ; <- lane1_*/lane2_*
//   Status       : <- buf_count (occupied entries)
// master = fetch/decode environment, slave = fetch_dispatch_ctrl.
interface fetch_dispatch_ctrl_if #(
  parameter int unsigned PTR_W = 3
);
  logic           in_valid;
  logic [3:0]     in_mask;
  logic [255:0]   in_pc;
  logic [127:0]   in_inst;
  logic           in_epoch;
  logic           in_ready;
  logic           cur_epoch;
  logic           flush;
  logic           stall1;
  logic           stall2;
  logic           lane1_valid;
  logic [63:0]    lane1_pc;
  logic [31:0]    lane1_inst;
  logic           lane2_valid;
  logic [63:0]    lane2_pc;
  logic [31:0]    lane2_inst;
  logic [PTR_W:0] buf_count;

  modport master (
    output in_valid, in_mask, in_pc, in_inst, in_epoch, flush, stall1, stall2,
    input  in_ready, cur_epoch, lane1_valid, lane1_pc, lane1_inst,
           lane2_valid, lane2_pc, lane2_inst, buf_count
  );

  modport slave (
    input  in_valid, in_mask, in_pc, in_inst, in_epoch, flush, stall1, stall2,
    output in_ready, cur_epoch, lane1_valid, lane1_pc, lane1_inst,
           lane2_valid, lane2_pc, lane2_inst, buf_count
  );
endinterface

// File: rtl/fetch_dispatch_ctrl.sv
// In-order instruction buffer and dual-lane dispatch scheduler.
// Compacts 4-wide masked fetch bundles into a circular buffer and issues the
// two oldest instructions per cycle into the decode1/decode2 lane registers.
// A 1-bit fetch epoch discards bundles requested before the last flush.
// Ports:
//   clk    : clock
//   rst    : synchronous, active-high reset
//   io_bus : fetch_dispatch_ctrl_if slave (fetch bundle in, lanes out, status)
module fetch_dispatch_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input logic                  clk,
  input logic                  rst,
  fetch_dispatch_ctrl_if.slave io_bus
);

  localparam logic [PTR_W:0] ReadyMax = (PTR_W + 1)'(DEPTH - 4);
  localparam logic [PTR_W:0] CntOne   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] CntTwo   = (PTR_W + 1)'(2);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_epoch;
  logic [63:0]      r_buf_pc   [DEPTH];
  logic [31:0]      r_buf_inst [DEPTH];

  logic        r_l1_valid;
  logic [63:0] r_l1_pc;
  logic [31:0] r_l1_inst;
  logic        r_l2_valid;
  logic [63:0] r_l2_pc;
  logic [31:0] r_l2_inst;

  logic             w_in_ready;
  logic             w_wr_fire;
  logic             w_adv;
  logic [2:0]       w_wr_n;
  logic [2:0]       w_wr_n_eff;
  logic [PTR_W-1:0] w_wr_idx [4];
  logic [PTR_W:0]   w_rd_n;
  logic [PTR_W-1:0] w_head_p1;

  // Only the registered count matters; a same-cycle dispatch does not open space.
  assign w_in_ready = (r_count <= ReadyMax);
  // Stale-epoch bundles still see in_ready, so the handshake completes and they drop.
  assign w_wr_fire  = io_bus.in_valid & w_in_ready & (io_bus.in_epoch == r_epoch) &
                      ~io_bus.flush;
  assign w_adv      = ~(io_bus.stall1 | io_bus.stall2) | ~r_l1_valid;
  assign w_head_p1  = r_head + (PTR_W)'(1);
  assign w_wr_n_eff = w_wr_fire ? w_wr_n : 3'd0;

  // Compaction: each set slot lands at tail + (number of set slots below it).
  always_comb begin
    w_wr_n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_wr_idx[i] = r_tail + (PTR_W)'(w_wr_n);
      w_wr_n      = w_wr_n + {2'b00, io_bus.in_mask[i]};
    end
  end

  // Read count uses the pre-write occupancy, so rd never exceeds count.
  always_comb begin
    w_rd_n = '0;
    if (w_adv) begin
      w_rd_n = (r_count >= CntTwo) ? CntTwo : r_count;
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by head/tail/count.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (io_bus.in_mask[i]) begin
          r_buf_pc[w_wr_idx[i]]   <= io_bus.in_pc[64*i +: 64];
          r_buf_inst[w_wr_idx[i]] <= io_bus.in_inst[32*i +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_epoch    <= 1'b0;
      r_l1_valid <= 1'b0;
      r_l1_pc    <= '0;
      r_l1_inst  <= '0;
      r_l2_valid <= 1'b0;
      r_l2_pc    <= '0;
      r_l2_inst  <= '0;
    end else if (io_bus.flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_epoch    <= ~r_epoch;
      r_l1_valid <= 1'b0;
      r_l1_pc    <= '0;
      r_l1_inst  <= '0;
      r_l2_valid <= 1'b0;
      r_l2_pc    <= '0;
      r_l2_inst  <= '0;
    end else begin
      r_tail  <= r_tail + (PTR_W)'(w_wr_n_eff);
      r_head  <= r_head + w_rd_n[PTR_W-1:0];
      r_count <= r_count + (PTR_W + 1)'(w_wr_n_eff) - w_rd_n;
      if (w_adv) begin
        if (r_count >= CntOne) begin
          r_l1_valid <= 1'b1;
          r_l1_pc    <= r_buf_pc[r_head];
          r_l1_inst  <= r_buf_inst[r_head];
        end else begin
          r_l1_valid <= 1'b0;
          r_l1_pc    <= '0;
          r_l1_inst  <= '0;
        end
        if (r_count >= CntTwo) begin
          r_l2_valid <= 1'b1;
          r_l2_pc    <= r_buf_pc[w_head_p1];
          r_l2_inst  <= r_buf_inst[w_head_p1];
        end else begin
          r_l2_valid <= 1'b0;
          r_l2_pc    <= '0;
          r_l2_inst  <= '0;
        end
      end
    end
  end

  assign io_bus.in_ready    = w_in_ready;
  assign io_bus.cur_epoch   = r_epoch;
  assign io_bus.lane1_valid = r_l1_valid;
  assign io_bus.lane1_pc    = r_l1_pc;
  assign io_bus.lane1_inst  = r_l1_inst;
  assign io_bus.lane2_valid = r_l2_valid;
  assign io_bus.lane2_pc    = r_l2_pc;
  assign io_bus.lane2_inst  = r_l2_inst;
  assign io_bus.buf_count   = r_count;

endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// Directed bench for fetch_dispatch_ctrl. Accepted instructions are pushed
// into a scoreboard queue when driven; lane contents are popped from it.
module tb_fetch_dispatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_dispatch_ctrl_if #(.PTR_W(3)) bus ();

  fetch_dispatch_ctrl #(
    .DEPTH(8),
    .PTR_W(3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard / reference state
  logic [63:0] sb_pc [$];
  logic [31:0] sb_inst [$];
  logic        m_epoch = 1'b0;
  logic        m_l1v = 1'b0, m_l2v = 1'b0;
  logic [63:0] m_l1pc = '0, m_l2pc = '0;
  logic [31:0] m_l1in = '0, m_l2in = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return 32'h1300_0000 ^ pc[31:0] ^ {pc[63:56], 24'h0};
  endfunction

  task automatic set_bundle(input logic [3:0] mask, input logic [63:0] base,
                            input logic epoch);
    bus.in_valid = 1'b1;
    bus.in_mask  = mask;
    bus.in_epoch = epoch;
    for (int i = 0; i < 4; i++) begin
      bus.in_pc[64*i +: 64]   = base + 64'(4 * i);
      bus.in_inst[32*i +: 32] = inst_of(base + 64'(4 * i));
    end
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_mask  = 4'h0;
  endtask

  // One clock: advance the model from the inputs now applied, then compare.
  task automatic tick();
    int  sz;
    bit  rdy;
    sz  = sb_pc.size();
    rdy = (8 - sz) >= 4;
    if (rst || bus.flush) begin
      sb_pc.delete();
      sb_inst.delete();
      m_epoch = rst ? 1'b0 : ~m_epoch;
      m_l1v = 0; m_l1pc = '0; m_l1in = '0;
      m_l2v = 0; m_l2pc = '0; m_l2in = '0;
    end else begin
      if (!(bus.stall1 || bus.stall2) || !m_l1v) begin
        if (sb_pc.size() > 0) begin
          m_l1v = 1; m_l1pc = sb_pc.pop_front(); m_l1in = sb_inst.pop_front();
        end else begin
          m_l1v = 0; m_l1pc = '0; m_l1in = '0;
        end
        if (sb_pc.size() > 0) begin
          m_l2v = 1; m_l2pc = sb_pc.pop_front(); m_l2in = sb_inst.pop_front();
        end else begin
          m_l2v = 0; m_l2pc = '0; m_l2in = '0;
        end
      end
      if (bus.in_valid && rdy && (bus.in_epoch == m_epoch)) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.in_mask[i]) begin
            sb_pc.push_back(bus.in_pc[64*i +: 64]);
            sb_inst.push_back(bus.in_inst[32*i +: 32]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("lane1_valid", 64'(bus.lane1_valid), 64'(m_l1v));
    chk("lane1_pc", bus.lane1_pc, m_l1pc);
    chk("lane1_inst", 64'(bus.lane1_inst), 64'(m_l1in));
    chk("lane2_valid", 64'(bus.lane2_valid), 64'(m_l2v));
    chk("lane2_pc", bus.lane2_pc, m_l2pc);
    chk("lane2_inst", 64'(bus.lane2_inst), 64'(m_l2in));
    chk("buf_count", 64'(bus.buf_count), 64'(sb_pc.size()));
    chk("in_ready", 64'(bus.in_ready), 64'((8 - sb_pc.size()) >= 4));
    chk("cur_epoch", 64'(bus.cur_epoch), 64'(m_epoch));
  endtask

  task automatic drain(input int n);
    idle_in();
    bus.stall1 = 0;
    bus.stall2 = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.in_valid = 0; bus.in_mask = '0; bus.in_pc = '0; bus.in_inst = '0;
    bus.in_epoch = 0; bus.flush = 0; bus.stall1 = 0; bus.stall2 = 0;

    // Reset state
    tick(); tick();
    rst = 0;
    chk("rst_count", 64'(bus.buf_count), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    // Full bundle, in-order dual issue
    set_bundle(4'b1111, 64'h8000_0000, 1'b0);
    tick();
    chk("b1_count4", 64'(bus.buf_count), 64'd4);
    idle_in();
    tick();
    chk("b1_l1pc", bus.lane1_pc, 64'h8000_0000);
    chk("b1_l2pc", bus.lane2_pc, 64'h8000_0004);
    chk("b1_count2", 64'(bus.buf_count), 64'd2);
    tick();
    chk("b1_l1pc_2", bus.lane1_pc, 64'h8000_0008);
    chk("b1_l2pc_2", bus.lane2_pc, 64'h8000_000C);
    chk("b1_count0", 64'(bus.buf_count), 64'd0);
    tick();

    // Holes compacted: slots 1 and 3 issue together
    set_bundle(4'b1010, 64'h1000, 1'b0);
    tick();
    idle_in();
    tick();
    chk("cmp_l1pc", bus.lane1_pc, 64'h1004);
    chk("cmp_l2pc", bus.lane2_pc, 64'h100C);
    tick();

    // Single instruction: lane2 empty and zeroed
    set_bundle(4'b0001, 64'h2000, 1'b0);
    tick();
    idle_in();
    tick();
    chk("one_l1v", 64'(bus.lane1_valid), 64'd1);
    chk("one_l2v", 64'(bus.lane2_valid), 64'd0);
    chk("one_l2pc", bus.lane2_pc, 64'd0);
    tick();

    // Stall1 held three cycles while streaming; buffer fills and wraps
    set_bundle(4'b0011, 64'h3000, 1'b0);
    tick();
    bus.stall1 = 1;
    set_bundle(4'b1111, 64'h3100, 1'b0);
    tick();
    set_bundle(4'b1111, 64'h3200, 1'b0);
    tick();
    chk("full_count", 64'(bus.buf_count), 64'd8);
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    set_bundle(4'b1111, 64'h3300, 1'b0);
    tick();
    chk("hold_l1pc", bus.lane1_pc, 64'h3000);
    drain(6);

    // Stall2 only: no partial issue
    set_bundle(4'b1111, 64'h4000, 1'b0);
    tick();
    idle_in();
    tick();
    bus.stall2 = 1;
    tick();
    tick();
    chk("s2_hold_l1pc", bus.lane1_pc, 64'h4000);
    chk("s2_hold_l2pc", bus.lane2_pc, 64'h4004);
    drain(3);

    // Flush at count 6, then stale and current-epoch bundles
    set_bundle(4'b1111, 64'h5000, 1'b0);
    tick();
    bus.stall1 = 1;
    set_bundle(4'b0011, 64'h5100, 1'b0);
    tick();
    set_bundle(4'b0011, 64'h5200, 1'b0);
    tick();
    chk("pre_flush_count", 64'(bus.buf_count), 64'd6);
    idle_in();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    bus.stall1 = 0;
    set_bundle(4'b1111, 64'h6000, 1'b0);
    tick();
    chk("stale_count", 64'(bus.buf_count), 64'd0);
    chk("stale_ready", 64'(bus.in_ready), 64'd1);
    chk("stale_epoch", 64'(bus.cur_epoch), 64'd1);
    set_bundle(4'b1111, 64'h7000, 1'b1);
    tick();
    idle_in();
    tick();
    chk("new_ep_l1pc", bus.lane1_pc, 64'h7000);
    drain(2);

    // Flush coincident with matching write and stall1
    set_bundle(4'b1111, 64'h8000, 1'b1);
    tick();
    idle_in();
    tick();
    set_bundle(4'b1111, 64'h8100, 1'b1);
    bus.stall1 = 1;
    bus.flush = 1;
    tick();
    bus.flush = 0;
    bus.stall1 = 0;
    chk("fw_count", 64'(bus.buf_count), 64'd0);
    chk("fw_l1v", 64'(bus.lane1_valid), 64'd0);
    chk("fw_l1pc", bus.lane1_pc, 64'd0);
    idle_in();
    tick();

    // Reset mid-stream after epoch has moved to 1
    bus.flush = 1;
    tick();
    bus.flush = 0;
    set_bundle(4'b1111, 64'h9000, 1'b1);
    tick();
    set_bundle(4'b0111, 64'h9100, 1'b1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_epoch", 64'(bus.cur_epoch), 64'd0);
    chk("mid_rst_l1v", 64'(bus.lane1_valid), 64'd0);
    chk("mid_rst_count", 64'(bus.buf_count), 64'd0);
    idle_in();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
